cmd_queue: RTL and testbench

Parametrised player-command FIFO for the Tetris core. Merges decoded UART keystrokes and debounced push-buttons into one ordered command stream. Held buttons auto-repeat. The game FSM consumes commands with an explicit pop handshake, replacing shift-on-WAIT behaviour. Sits between the uart/debouncer front end and the game state machine.

---
 rtl/cmd_queue_pkg.sv | 42 ++++
 rtl/cmd_queue_key_repeat.sv | 58 +++++
 rtl/cmd_queue.sv | 165 ++++++++++++++++
 tb/tb_cmd_queue.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_queue_pkg.sv
// ---------------------------------------------------------------------------
// cmd_queue_pkg
// Shared command encoding for the Tetris player-command path.
//   state_type       : 4-bit player command code (NONE = no command)
//   DEFAULT_BTN_CMD  : default btn_cmd bus, btn[0..3] = RIGHT, DOWN, LEFT, ROTATE
//   ascii_to_cmd()   : case-insensitive keystroke decode, NONE if unmapped
// ---------------------------------------------------------------------------
package cmd_queue_pkg;

   typedef enum logic [3:0] {
      NONE       = 4'd0,
      LEFT       = 4'd1,
      RIGHT      = 4'd2,
      DOWN       = 4'd3,
      DROP       = 4'd4,
      ROTATE     = 4'd5,
      ROTATE_REV = 4'd6,
      HOLD       = 4'd7
   } state_type;

   // Slice i of the bus is the command for btn[i]; btn[0] sits in the low nibble.
   localparam logic [15:0] DEFAULT_BTN_CMD = {ROTATE, LEFT, DOWN, RIGHT};

   function automatic state_type ascii_to_cmd(input logic [7:0] b);
      state_type c;
      c = NONE;
      // Forcing bit 5 folds 'A'..'Z' onto 'a'..'z'; only the two cases of a
      // letter can land on a given lowercase code.
      case (b | 8'h20)
         8'h61:   c = LEFT;        // a
         8'h64:   c = RIGHT;       // d
         8'h77:   c = DOWN;        // w
         8'h73:   c = DROP;        // s
         8'h63:   c = HOLD;        // c
         8'h78:   c = ROTATE;      // x
         8'h7a:   c = ROTATE_REV;  // z
         default: c = NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cmd_queue_key_repeat.sv
// ---------------------------------------------------------------------------
// key_repeat
// Turns one debounced button level into command events: one on the press,
// then (if REPEAT_EN) one after REPEAT_DELAY held cycles and one every
// REPEAT_PERIOD cycles after that. Releasing the button restarts the timer.
//   clk, reset_n : clock, synchronous active-low reset
//   btn_i        : debounced level, 1 = pressed
//   event_o      : one-cycle event strobe (combinational from registered state)
// ---------------------------------------------------------------------------
module key_repeat #(
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_i,
   output logic event_o
);

   logic        btn_q;
   logic [31:0] cnt_q, cnt_d;
   logic        rep_q, rep_d;   // 0: waiting out the initial delay, 1: repeating
   logic        rise, fire;

   // cnt_q equals the number of cycles the button has been held since the
   // press (or since the last repeat once rep_q is set).
   always_comb begin
      rise  = btn_i & ~btn_q;
      fire  = 1'b0;
      cnt_d = '0;
      rep_d = 1'b0;
      if (REPEAT_EN && btn_i) begin
         if (rep_q ? (cnt_q == 32'(REPEAT_PERIOD)) : (cnt_q == 32'(REPEAT_DELAY))) begin
            fire  = 1'b1;
            cnt_d = 32'd1;
            rep_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 32'd1;
            rep_d = rep_q;
         end
      end
      event_o = rise | fire;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         btn_q <= 1'b0;
         cnt_q <= '0;
         rep_q <= 1'b0;
      end else begin
         btn_q <= btn_i;
         cnt_q <= cnt_d;
         rep_q <= rep_d;
      end
   end

endmodule

// File: rtl/cmd_queue.sv
// ---------------------------------------------------------------------------
// cmd_queue
// Merges UART keystrokes and push-button events into one ordered command FIFO
// for the game FSM, which consumes entries with a pop handshake.
//   clk, reset_n : clock, synchronous active-low reset
//   rx_valid     : rx_byte holds a received UART byte this cycle
//   rx_byte      : received ASCII byte
//   btn          : debounced button levels, 1 = pressed
//   btn_cmd      : 4-bit command per button, slice i for btn[i]
//   pop          : consumer takes the head entry this cycle
//   head         : head command, NONE when empty
//   head_valid   : FIFO not empty
//   count        : occupancy
//   full         : count == DEPTH
//   drop_cnt     : saturating count of commands lost to pending-slot collisions
// ---------------------------------------------------------------------------
module cmd_queue
   import cmd_queue_pkg::*;
#(
   parameter int          DEPTH         = 16,
   parameter int          NBTN          = 4,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_byte,
   input  logic [NBTN-1:0]        btn,
   input  logic [NBTN*4-1:0]      btn_cmd,
   input  logic                   pop,
   output state_type              head,
   output logic                   head_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic [7:0]             drop_cnt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int NSRC = NBTN + 1;   // source 0 is the UART, source i+1 is btn[i]

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] n);
      logic [8:0] s;
      s = {1'b0, a} + 9'(n);
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   // Button event generators
   logic [NBTN-1:0] btn_evt;

   for (genvar g = 0; g < NBTN; g++) begin : g_rep
      key_repeat #(
         .REPEAT_EN     (REPEAT_EN),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_key_repeat (
         .clk     (clk),
         .reset_n (reset_n),
         .btn_i   (btn[g]),
         .event_o (btn_evt[g])
      );
   end

   // Storage and control state
   state_type       mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      drop_q, drop_d;
   logic [NSRC-1:0] pend_q, pend_d;
   state_type       pend_cmd_q [NSRC];

   // Combinational signals
   state_type       rx_cmd;
   logic [NSRC-1:0] src_evt;
   state_type       src_cmd [NSRC];
   logic [NSRC-1:0] grant, drop_vec, load;
   logic [3:0]      ndrops;
   state_type       wr_cmd;
   logic            do_wr, do_pop, found;

   always_comb begin
      rx_cmd     = ascii_to_cmd(rx_byte);
      src_evt[0] = rx_valid && (rx_cmd != NONE);
      src_cmd[0] = rx_cmd;
      for (int i = 0; i < NBTN; i++) begin
         src_evt[i+1] = btn_evt[i];
         src_cmd[i+1] = state_type'(btn_cmd[4*i +: 4]);
      end
   end

   // Fixed-priority arbiter: lowest source index wins. A write is allowed when
   // there is room, or when a pop frees the head slot in the same cycle.
   always_comb begin
      do_pop = pop && (count_q != '0);
      do_wr  = (|pend_q) && ((count_q < CW'(DEPTH)) || do_pop);
      grant  = '0;
      wr_cmd = NONE;
      found  = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (pend_q[i] && !found) begin
            found    = 1'b1;
            grant[i] = do_wr;
            wr_cmd   = pend_cmd_q[i];
         end
      end
   end

   // A slot being drained this cycle can accept a new event without a drop,
   // so a source producing one command per cycle keeps flowing.
   always_comb begin
      ndrops = '0;
      for (int i = 0; i < NSRC; i++) begin
         drop_vec[i] = src_evt[i] & pend_q[i] & ~grant[i];
         load[i]     = src_evt[i] & ~drop_vec[i];
         pend_d[i]   = (pend_q[i] & ~grant[i]) | src_evt[i];
         ndrops      = ndrops + 4'(drop_vec[i]);
      end
   end

   always_comb begin
      wr_ptr_d = do_wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({do_wr, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      drop_d = sat_add8(drop_q, ndrops);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         pend_q   <= pend_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Payload registers carry no reset; their valid bits above gate them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (load[i]) pend_cmd_q[i] <= src_cmd[i];
      end
      if (do_wr) mem_q[wr_ptr_q] <= wr_cmd;
   end

   assign head       = (count_q == '0) ? NONE : mem_q[rd_ptr_q];
   assign head_valid = (count_q != '0);
   assign count      = count_q;
   assign full       = (count_q == CW'(DEPTH));
   assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_cmd_queue.sv
module tb_cmd_queue;
   import cmd_queue_pkg::*;

   localparam int DEPTH  = 4;
   localparam int NBTN   = 4;
   localparam int DELAY  = 20;
   localparam int PERIOD = 10;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk;
   logic              reset_n;
   logic              rx_valid;
   logic [7:0]        rx_byte;
   logic [NBTN-1:0]   btn;
   logic [NBTN*4-1:0] btn_cmd;
   logic              pop;
   state_type         head;
   logic              head_valid;
   logic [CW-1:0]     count;
   logic              full;
   logic [7:0]        drop_cnt;

   cmd_queue #(
      .DEPTH         (DEPTH),
      .NBTN          (NBTN),
      .REPEAT_EN     (1'b1),
      .REPEAT_DELAY  (DELAY),
      .REPEAT_PERIOD (PERIOD)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .btn        (btn),
      .btn_cmd    (btn_cmd),
      .pop        (pop),
      .head       (head),
      .head_valid (head_valid),
      .count      (count),
      .full       (full),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Keystroke table: lowercase letters then the same letters uppercase.
   logic [7:0] letters [14] = '{8'h61, 8'h64, 8'h77, 8'h73, 8'h63, 8'h78, 8'h7a,
                                8'h41, 8'h44, 8'h57, 8'h53, 8'h43, 8'h58, 8'h5a};
   logic [3:0] cmd_of  [7]  = '{LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV};

   function automatic logic [3:0] m_decode(input logic [7:0] b);
      for (int k = 0; k < 14; k++)
         if (b == letters[k]) return cmd_of[k % 7];
      return NONE;
   endfunction

   // ---------------- behavioural model ----------------
   logic [3:0] mq [$];
   bit         m_pend [NBTN+1];
   logic [3:0] m_pcmd [NBTN+1];
   int         m_hold [NBTN];
   int         m_drop;
   bit         m_ev [NBTN+1];
   logic [3:0] m_ec [NBTN+1];
   int         m_sel;
   bit         m_popping, m_wr;

   always @(posedge clk) begin
      if (!reset_n) begin
         mq.delete();
         for (int i = 0; i <= NBTN; i++) m_pend[i] = 1'b0;
         for (int i = 0; i < NBTN; i++) m_hold[i] = 0;
         m_drop = 0;
      end else begin
         m_ec[0] = m_decode(rx_byte);
         m_ev[0] = rx_valid && (m_ec[0] != NONE);
         for (int i = 0; i < NBTN; i++) begin
            m_ec[i+1] = btn_cmd[4*i +: 4];
            if (btn[i]) begin
               // m_hold = cycles already held before this one
               m_ev[i+1] = (m_hold[i] == 0) ||
                           (m_hold[i] >= DELAY && ((m_hold[i] - DELAY) % PERIOD) == 0);
               m_hold[i]++;
            end else begin
               m_ev[i+1] = 1'b0;
               m_hold[i] = 0;
            end
         end
         m_sel = -1;
         for (int i = NBTN; i >= 0; i--) if (m_pend[i]) m_sel = i;
         m_popping = pop && (mq.size() > 0);
         m_wr      = (m_sel >= 0) && ((mq.size() < DEPTH) || m_popping);
         if (m_popping) void'(mq.pop_front());
         if (m_wr) begin
            mq.push_back(m_pcmd[m_sel]);
            m_pend[m_sel] = 1'b0;
         end
         for (int i = 0; i <= NBTN; i++) begin
            if (m_ev[i]) begin
               if (m_pend[i]) begin
                  if (m_drop < 255) m_drop++;
               end else begin
                  m_pend[i] = 1'b1;
                  m_pcmd[i] = m_ec[i];
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_head",       head,       (mq.size() > 0) ? mq[0] : NONE);
         chk("model_head_valid", head_valid, mq.size() > 0);
         chk("model_count",      count,      mq.size());
         chk("model_full",       full,       mq.size() == DEPTH);
         chk("model_drop_cnt",   drop_cnt,   m_drop);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      btn      = '0;
      btn_cmd  = DEFAULT_BTN_CMD;
      pop      = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Reset state
      chk("rst_count", count, 0);
      chk("rst_head", head, NONE);
      chk("rst_head_valid", head_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_drop", drop_cnt, 0);

      // "a" then "X"
      rx_valid = 1'b1; rx_byte = 8'h61; step();
      rx_byte = 8'h58; step();
      rx_valid = 1'b0;
      chk("ax_head_n2", head, LEFT);
      chk("ax_count_n2", count, 1);
      step();
      chk("ax_count", count, 2);
      pop = 1'b1; step();
      chk("ax_pop1_head", head, ROTATE);
      step();
      chk("ax_pop2_head", head, NONE);
      chk("ax_pop2_valid", head_valid, 0);
      step();                      // pop while empty is ignored
      pop = 1'b0;
      chk("ax_empty_pop_count", count, 0);

      // Same-cycle UART "d" and btn[2] press: UART wins
      rx_valid = 1'b1; rx_byte = 8'h64; btn[2] = 1'b1; step();
      rx_valid = 1'b0; btn = '0;
      step(); step();
      chk("same_count", count, 2);
      chk("same_head0", head, RIGHT);
      chk("same_drop", drop_cnt, 0);
      pop = 1'b1; step();
      chk("same_head1", head, LEFT);
      step(); pop = 1'b0;
      chk("same_empty", count, 0);

      // Six UART commands with no pop: 4 stored, 1 held pending, 1 dropped
      do_reset();
      for (int j = 0; j < 6; j++) begin
         rx_valid = 1'b1; rx_byte = letters[j]; step();
         rx_valid = 1'b0;
         repeat (9) step();
      end
      chk("full_count", count, 4);
      chk("full_flag", full, 1);
      chk("full_drop", drop_cnt, 1);
      pop = 1'b1;
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("full_pop_head%0d", j), head, cmd_of[j]);
         step();
      end
      pop = 1'b0;
      chk("full_drained", count, 0);

      // Held btn[1] for 45 cycles: press + repeats at 20, 30, 40
      do_reset();
      btn[1] = 1'b1;
      repeat (45) step();
      btn[1] = 1'b0;
      repeat (3) step();
      chk("rep_count", count, 4);
      chk("rep_drop", drop_cnt, 0);
      pop = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("rep_head%0d", j), head, DOWN);
         step();
      end
      pop = 1'b0;
      chk("rep_drained", count, 0);

      // Push and pop every cycle at count 1, across several pointer wraps
      do_reset();
      rx_valid = 1'b1;
      rx_byte = letters[0]; step();
      rx_byte = letters[1]; step();
      pop = 1'b1;
      for (int k = 2; k < 16; k++) begin
         rx_byte = letters[k % 14];
         chk($sformatf("stream_count%0d", k), count, 1);
         chk($sformatf("stream_head%0d", k), head, cmd_of[(k-2) % 7]);
         step();
      end
      rx_valid = 1'b0; pop = 1'b0;
      step();
      chk("stream_tail_count", count, 2);
      chk("stream_tail_head", head, cmd_of[14 % 7]);
      chk("stream_drop", drop_cnt, 0);

      // Reset mid-operation with count = 3, rx in the reset cycle ignored
      do_reset();
      rx_valid = 1'b1;
      rx_byte = letters[0]; step();
      rx_byte = letters[1]; step();
      rx_byte = letters[2]; step();
      rx_valid = 1'b0;
      step();
      chk("mid_count3", count, 3);
      reset_n = 1'b0; rx_valid = 1'b1; rx_byte = letters[3]; step();
      chk("mid_rst_count", count, 0);
      chk("mid_rst_head", head, NONE);
      reset_n = 1'b1; rx_valid = 1'b0;
      repeat (3) step();
      chk("mid_after_count", count, 0);

      // Drop counter saturation
      rx_valid = 1'b1; rx_byte = 8'h7a;
      repeat (280) step();
      rx_valid = 1'b0;
      chk("sat_drop", drop_cnt, 255);
      chk("sat_full", full, 1);
      do_reset();

      // Randomised traffic
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) btn_cmd = 16'($urandom);
         for (int i = 0; i < NBTN; i++)
            if ($urandom_range(0, 29) == 0) btn[i] = ~btn[i];
         rx_valid = ($urandom_range(0, 3) == 0);
         rx_byte  = ($urandom_range(0, 1) == 0) ? letters[$urandom_range(0, 13)]
                                                : 8'($urandom_range(0, 255));
         pop      = ($urandom_range(0, 2) == 0);
         reset_n  = ($urandom_range(0, 599) != 0);
         step();
      end
      reset_n = 1'b1; rx_valid = 1'b0; pop = 1'b0; btn = '0;
      repeat (5) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
